// File: rtl/io_clk_pkg.sv
// io_clk_pkg: shared divisor type and constants for the IO tick generator.
package io_clk_pkg;
  localparam int IO_DIV_WIDTH_DEFAULT = 16;
  typedef logic [IO_DIV_WIDTH_DEFAULT-1:0] io_div_t;
  localparam io_div_t IO_DIV_DISABLED = '0;
endpackage

// File: rtl/io_clk_tick_channel.sv
// io_clk_tick_channel: one divider channel with glitch-free divisor swap at the fall boundary.
module io_clk_tick_channel
  import io_clk_pkg::*;
#(
  parameter int DIV_WIDTH = IO_DIV_WIDTH_DEFAULT,
  parameter int RESET_DIV = 0
) (
  input  logic                 sys_clk,
  input  logic                 async_rst_n,
  input  logic                 sync_rst,
  input  logic                 clk_en,
  input  logic                 update,
  input  logic [DIV_WIDTH-1:0] select,
  output logic                 tick,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic                 pending,
  output logic [DIV_WIDTH-1:0] active_div
);
  localparam logic [DIV_WIDTH-1:0] ONE = 1;
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] RST_CNT = (RESET_DIV == 0) ? '0 : RST_DIV - ONE;
  logic [DIV_WIDTH-1:0] count, count_n, pending_div, pending_div_n, active_n;
  logic wrap, apply, level_n, pending_n;
  // wrap marks the half-period boundary; apply only at the fall edge or while idle
  assign wrap          = clk_en && active_div != '0 && count == '0;
  assign apply         = clk_en && pending && (active_div == '0 || (wrap && level));
  assign active_n      = apply ? pending_div : active_div;
  assign count_n       = apply ? (pending_div == '0 ? '0 : pending_div - ONE)
                       : wrap ? active_div - ONE
                       : (clk_en && active_div != '0) ? count - ONE : count;
  assign level_n       = wrap ? ~level : level;
  assign pending_n     = (clk_en && update) || (pending && !apply);
  assign pending_div_n = (clk_en && update) ? select : pending_div;
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n || sync_rst) begin
      count       <= RST_CNT;
      active_div  <= RST_DIV;
      pending_div <= '0;
      pending     <= 1'b0;
      level       <= 1'b0;
      tick        <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
    end else begin
      count       <= count_n;
      active_div  <= active_n;
      pending_div <= pending_div_n;
      pending     <= pending_n;
      level       <= level_n;
      tick        <= wrap;
      rise        <= wrap && !level;
      fall        <= wrap && level;
    end
  end
endmodule

// File: rtl/io_clk_tick_gen.sv
// io_clk_tick_gen: multi-channel clock-enable tick generator on sys_clk; top only slices ports.
module io_clk_tick_gen
  import io_clk_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = IO_DIV_WIDTH_DEFAULT,
  parameter int RESET_DIV    = 0
) (
  input  logic                                   sys_clk,
  input  logic                                   async_rst_n,
  input  logic                                   sync_rst,
  input  logic                                   clk_en,
  input  logic [NUM_CHANNELS-1:0]                ClockUpdate,
  input  logic [NUM_CHANNELS-1:0][DIV_WIDTH-1:0] ClockSelect,
  output logic [NUM_CHANNELS-1:0]                tick,
  output logic [NUM_CHANNELS-1:0]                level,
  output logic [NUM_CHANNELS-1:0]                rise,
  output logic [NUM_CHANNELS-1:0]                fall,
  output logic [NUM_CHANNELS-1:0]                pending,
  output logic [NUM_CHANNELS-1:0][DIV_WIDTH-1:0] active_div
);
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    io_clk_tick_channel #(.DIV_WIDTH(DIV_WIDTH), .RESET_DIV(RESET_DIV)) u_ch (
      .sys_clk    (sys_clk),
      .async_rst_n(async_rst_n),
      .sync_rst   (sync_rst),
      .clk_en     (clk_en),
      .update     (ClockUpdate[g]),
      .select     (ClockSelect[g]),
      .tick       (tick[g]),
      .level      (level[g]),
      .rise       (rise[g]),
      .fall       (fall[g]),
      .pending    (pending[g]),
      .active_div (active_div[g])
    );
  end
endmodule
